// File: rtl/rgb_compare_scheduler_if.sv
// Requester, comparator and LED signal bundle for rgb_compare_scheduler.
// The scheduler connects through the slave modport. The master modport is the
// side that raises requests and evaluates the comparator.
interface rgb_compare_scheduler_if #(
  parameter int unsigned N_REQ = 4
);

  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] a_in;
  logic [2*N_REQ-1:0] b_in;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [2:0]         result;
  logic [1:0]         cmp_a;
  logic [1:0]         cmp_b;
  logic               cmp_red;
  logic               cmp_green;
  logic               cmp_blue;
  logic               led_red;
  logic               led_green;
  logic               led_blue;
  logic               busy;
  logic               err;

  modport master (
    output req, a_in, b_in, cmp_red, cmp_green, cmp_blue,
    input  gnt, done, result, cmp_a, cmp_b, led_red, led_green, led_blue, busy, err
  );

  modport slave (
    input  req, a_in, b_in, cmp_red, cmp_green, cmp_blue,
    output gnt, done, result, cmp_a, cmp_b, led_red, led_green, led_blue, busy, err
  );

endinterface

// File: rtl/rgb_compare_scheduler.sv
// Round-robin scheduler that shares one combinational 2-bit comparator among
// N_REQ requesters. It shows each verdict on the RGB LED for DWELL cycles.
module rgb_compare_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DWELL = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  rgb_compare_scheduler_if.slave bus
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StEval = 2'd1;
  localparam logic [1:0] StShow = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic [IdxW-1:0]  win_q, win_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [2:0]       result_q, result_d;
  logic [1:0]       cmp_a_q, cmp_a_d;
  logic [1:0]       cmp_b_q, cmp_b_d;
  logic [2:0]       led_q, led_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             win_found;
  logic [IdxW-1:0]  win_idx;
  logic [31:0]      cand;
  logic [2:0]       verdict;
  logic             verdict_ok;

  assign verdict    = {bus.cmp_red, bus.cmp_green, bus.cmp_blue};
  assign verdict_ok = (verdict == 3'b100) || (verdict == 3'b010) || (verdict == 3'b001);

  // Round-robin search starting just after the last granted index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(last_q) + k) % N_REQ;
      if (!win_found && bus.req[cand[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
  end

  // Next-state logic. Every output is registered, so grant and operands are set up on
  // the IDLE->EVAL edge.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    gnt_d    = '0;
    done_d   = '0;
    result_d = result_q;
    cmp_a_d  = '0;
    cmp_b_d  = '0;
    led_d    = led_q;
    busy_d   = busy_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StEval;
          win_d   = win_idx;
          gnt_d   = N_REQ'(1) << win_idx;
          cmp_a_d = bus.a_in[{win_idx, 1'b0} +: 2];
          cmp_b_d = bus.b_in[{win_idx, 1'b0} +: 2];
          busy_d  = 1'b1;
        end
      end
      StEval: begin
        // The comparator settles during EVAL and its verdict is captured at the end.
        result_d = verdict;
        led_d    = verdict;
        last_d   = win_q;
        done_d   = gnt_q;
        cnt_d    = CntW'(DWELL - 1);
        state_d  = StShow;
        if (!verdict_ok) begin
          err_d = 1'b1;
        end
      end
      StShow: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          led_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        led_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      last_q   <= IdxW'(N_REQ - 1);
      win_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      cmp_a_q  <= '0;
      cmp_b_q  <= '0;
      led_q    <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      cmp_a_q  <= cmp_a_d;
      cmp_b_q  <= cmp_b_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.cmp_a     = cmp_a_q;
  assign bus.cmp_b     = cmp_b_q;
  assign bus.led_red   = led_q[2];
  assign bus.led_green = led_q[1];
  assign bus.led_blue  = led_q[0];
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_rgb_compare_scheduler.sv
// Directed scoreboard bench for rgb_compare_scheduler (N_REQ=4, DWELL=8).
module tb_rgb_compare_scheduler;

  localparam int unsigned NReq  = 4;
  localparam int unsigned Dwell = 8;

  typedef struct {
    int         idx;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] res;
  } sb_t;

  logic clk;
  logic rst_n;
  logic fault;
  int   cyc;
  int   n_err;
  int   n_checks;
  sb_t  sb[$];

  rgb_compare_scheduler_if #(.N_REQ(NReq)) bus ();

  rgb_compare_scheduler #(
    .N_REQ(NReq),
    .DWELL(Dwell)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Comparator model; the fault switch forces an illegal two-hot verdict.
  always_comb begin
    if (fault) begin
      {bus.cmp_red, bus.cmp_green, bus.cmp_blue} = 3'b110;
    end else begin
      bus.cmp_red   = (bus.cmp_a > bus.cmp_b);
      bus.cmp_green = (bus.cmp_a == bus.cmp_b);
      bus.cmp_blue  = (bus.cmp_a < bus.cmp_b);
    end
  end

  function automatic logic [2:0] golden(input logic [1:0] a, input logic [1:0] b);
    if (a > b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'd1;
    return one << i;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " gnt"}, 32'(bus.gnt), 0);
    check({tag, " done"}, 32'(bus.done), 0);
    check({tag, " result"}, 32'(bus.result), 0);
    check({tag, " cmp"}, 32'({bus.cmp_a, bus.cmp_b}), 0);
    check({tag, " led"}, 32'({bus.led_red, bus.led_green, bus.led_blue}), 0);
    check({tag, " busy"}, 32'(bus.busy), 0);
    check({tag, " err"}, 32'(bus.err), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    fault    = 1'b0;
    repeat (2) @(negedge clk);
    check_idle(tag);
    rst_n = 1'b1;
  endtask

  // Raise a request and push its expected verdict.
  task automatic push_req(input int idx, input logic [1:0] a, input logic [1:0] b,
                          input logic [2:0] res);
    sb_t e;
    bus.a_in[2*idx +: 2] = a;
    bus.b_in[2*idx +: 2] = b;
    bus.req[idx]         = 1'b1;
    e.idx = idx;
    e.a   = a;
    e.b   = b;
    e.res = res;
    sb.push_back(e);
  endtask

  // Wait for the next grant, then compare EVAL and first-SHOW outputs with the head of the
  // scoreboard. Returns at the done cycle after dropping that requester's req.
  task automatic collect(input string tag, output int gstart);
    sb_t e;
    bit  seen;
    e      = sb.pop_front();
    seen   = 1'b0;
    gstart = -1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.gnt != '0) seen = 1'b1;
    end
    check({tag, " grant seen"}, 32'(seen), 1);
    if (seen) begin
      gstart = cyc;
      check({tag, " gnt"}, 32'(bus.gnt), 32'(oh(e.idx)));
      check({tag, " busy"}, 32'(bus.busy), 1);
      check({tag, " cmp_a/b"}, 32'({bus.cmp_a, bus.cmp_b}), 32'({e.a, e.b}));
      check({tag, " done early"}, 32'(bus.done), 0);
      @(negedge clk);
      check({tag, " gnt drop"}, 32'(bus.gnt), 0);
      check({tag, " done"}, 32'(bus.done), 32'(oh(e.idx)));
      check({tag, " result"}, 32'(bus.result), 32'(e.res));
      check({tag, " led"}, 32'({bus.led_red, bus.led_green, bus.led_blue}), 32'(e.res));
      bus.req[e.idx] = 1'b0;
    end
  endtask

  initial begin
    int g0, g1, g2, g3, red_cycles, gx;
    n_err    = 0;
    n_checks = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    fault    = 1'b0;
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;

    // Single request: A>B shows red for exactly DWELL cycles.
    do_reset("reset");
    @(negedge clk);
    push_req(1, 2'b10, 2'b01, 3'b100);
    collect("single", g0);
    red_cycles = bus.led_red ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.led_red) red_cycles++;
      if (bus.done != '0) check("single done once", 32'(bus.done), 0);
    end
    check("single led cycles", 32'(red_cycles), Dwell);
    check("single busy after", 32'(bus.busy), 0);

    // All four requesting from reset: 0,1,2,3 each DWELL+2 apart.
    do_reset("reset2");
    push_req(0, 2'b11, 2'b11, 3'b010);
    push_req(1, 2'b11, 2'b11, 3'b010);
    push_req(2, 2'b11, 2'b11, 3'b010);
    push_req(3, 2'b11, 2'b11, 3'b010);
    collect("all r0", g0);
    collect("all r1", g1);
    collect("all r2", g2);
    collect("all r3", g3);
    check("spacing 0-1", 32'(g1 - g0), Dwell + 2);
    check("spacing 1-2", 32'(g2 - g1), Dwell + 2);
    check("spacing 2-3", 32'(g3 - g2), Dwell + 2);

    // Fairness: after 2 is served, 3 beats 0.
    push_req(2, 2'b00, 2'b10, 3'b001);
    collect("fair r2", gx);
    push_req(3, 2'b00, 2'b01, 3'b001);
    push_req(0, 2'b01, 2'b00, 3'b100);
    collect("fair r3", gx);
    collect("fair r0", gx);

    // Sweep all operand pairs through requester 0.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        push_req(0, 2'(a), 2'(b), golden(2'(a), 2'(b)));
        collect($sformatf("sweep a=%0d b=%0d", a, b), gx);
      end
    end
    check("sweep err", 32'(bus.err), 0);

    // Faulty comparator: err sets and is sticky until reset.
    fault = 1'b1;
    push_req(1, 2'b01, 2'b01, 3'b110);
    collect("fault", gx);
    fault = 1'b0;
    check("fault err set", 32'(bus.err), 1);
    push_req(2, 2'b11, 2'b00, 3'b100);
    collect("after fault", gx);
    check("fault err sticky", 32'(bus.err), 1);
    repeat (12) @(negedge clk);
    check("fault err held", 32'(bus.err), 1);
    do_reset("reset3");

    // Reset during the third SHOW cycle aborts the transaction.
    @(negedge clk);
    bus.a_in[3:2] = 2'b00;
    bus.b_in[3:2] = 2'b11;
    bus.req[1]    = 1'b1;
    gx = 0;
    for (int i = 0; i < 20 && bus.gnt == '0; i++) @(negedge clk);
    check("abort gnt", 32'(bus.gnt), 32'(oh(1)));
    repeat (3) @(negedge clk);
    check("abort show3 busy", 32'(bus.busy), 1);
    check("abort show3 led", 32'({bus.led_red, bus.led_green, bus.led_blue}), 3'b001);
    rst_n   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    check_idle("abort");
    @(negedge clk);
    check("abort no done", 32'(bus.done), 0);
    rst_n = 1'b1;
    // Pointer back at reset priority: 0 wins over 2 despite 1 being last granted.
    push_req(0, 2'b10, 2'b11, 3'b001);
    push_req(2, 2'b11, 2'b10, 3'b100);
    collect("post-abort r0", gx);
    collect("post-abort r2", gx);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rgb_compare_scheduler.md
# rgb_compare_scheduler

Sequencer and round-robin arbiter that shares a single combinational 2-bit magnitude comparator among N_REQ requesters. Each requester presents two 2-bit operands. The block grants one requester at a time, drives the comparator, latches its red/green/blue verdict, returns it to the requester and holds it on the board RGB LED for a programmable dwell time. It sits between the requesting logic and the comparator/LED pins.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DWELL, 8, cycles the LED holds each verdict (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req  in  N_REQ  level request per requester; held until its done pulse
- a_in  in  2*N_REQ  operand A per requester, requester i at [2i+1:2i]
- b_in  in  2*N_REQ  operand B per requester, same packing
- gnt  out  N_REQ  one-hot grant, high during EVAL only
- done  out  N_REQ  one-cycle pulse to the served requester
- result  out  3  latched verdict {red,green,blue}, valid with done, held until next capture
- cmp_a, cmp_b  out  2 each  operands driven to the comparator
- cmp_red, cmp_green, cmp_blue  in  1 each  comparator outputs: red=A>B, green=A==B, blue=A<B
- led_red, led_green, led_blue  out  1 each  LED drive
- busy  out  1  high in EVAL and SHOW
- err  out  1  sticky; set when a captured verdict is not exactly one-hot

## Operation
- States: IDLE, EVAL, SHOW.
- IDLE: if any req bit is high, select the winner round-robin, starting from the index after the last granted index (wrapping N_REQ-1 to 0). Go to EVAL. Otherwise stay in IDLE.
- EVAL (1 cycle): gnt[winner]=1. cmp_a/cmp_b are driven from the winner's slice. At the end of the cycle, cmp_* is registered into result and the last-granted pointer is updated. Go to SHOW.
- SHOW (DWELL cycles):
  - led_* = result.
  - done[winner] pulses in the first SHOW cycle only.
  - A down-counter loads DWELL-1 on entry; the block leaves SHOW when the counter reaches 0.
  - Go to IDLE.
- A requester deasserts req no later than the cycle after its done. If req is still high in IDLE, it is a new request and competes normally.
- Outside EVAL, cmp_a and cmp_b are 0. Outside SHOW, led_* are 0.
- Error check: if the captured verdict has a one-count ≠ 1, err is set. It is cleared only by reset. The verdict is still returned unchanged.
- Reset values:
  - state=IDLE, last-granted pointer=N_REQ-1 (so requester 0 has top priority first).
  - gnt=0, done=0, result=0, cmp_a=cmp_b=0, led_*=0, busy=0, err=0, counter=0.
- Reset mid-operation (EVAL or SHOW) aborts the transaction. No done is issued, and all state returns to reset values on the next edge.
- Requests arriving during EVAL or SHOW are not sampled until IDLE. They are never dropped while req stays high.

## Timing
- req first seen high in IDLE at edge t: EVAL in cycle t+1 (gnt high), done and result valid in cycle t+2, LED on for cycles t+2..t+1+DWELL, IDLE in cycle t+2+DWELL.
- Service period per transaction: DWELL+2 cycles. Back-to-back grants are separated by exactly one IDLE cycle.
- gnt, done, busy, led_* and cmp_* are registered outputs (no combinational path from req).
- The comparator path is combinational within EVAL: cmp_* in to result register within one cycle.

## Test plan
- Single request: DWELL=8; req[1]=1 with a=2'b10, b=2'b01 → gnt=0010 for one cycle, done[1] two cycles after req is sampled, result=3'b100, led_red high for exactly 8 cycles, then busy=0.
- All four requesting out of reset, all with a=b=2'b11 → grants in order 0,1,2,3. Each result=3'b010. Grant starts are 10 cycles apart.
- Fairness: after requester 2 is served, req=1001 → requester 3 is granted before requester 0.
- Equal/less sweep: all 16 (a,b) pairs through requester 0 against a golden comparator model → result matches the model each time, err stays 0.
- Faulty comparator model returns 3'b110 → err rises after that EVAL and stays high through later good transactions until rst_n=0.
- Reset mid-SHOW (cycle 3 of 8) → next cycle all outputs are 0, no done pulse. A subsequent req[2] is granted with the pointer back at reset priority.
